// File: rtl/mine_place_ctrl.sv
// ---------------------------------------------------------------------------
// mine_place_ctrl : places bombs on the 8x8 map (LFSR draws, then linear scan)
// Optional macro: MINE_SEED_FREERUN_EN (LFSR free-runs in IDLE). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mine_place_ctrl #(
  parameter int          MAX_BOMBS    = 40,
  parameter int          MAX_TRIES    = 512,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  bomb_count,
  input  logic [15:0] seed,
  input  logic        excl_en,
  input  logic [2:0]  excl_row,
  input  logic [2:0]  excl_col,
  output logic        busy,
  output logic        done,
  output logic [63:0] bomb_map,
  output logic [5:0]  placed_count
);

  localparam int          TW         = $clog2(MAX_TRIES) + 1;
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [5:0]  MAX_B      = 6'(MAX_BOMBS);
  localparam logic [15:0] TAPS       = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_DRAW  = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [TW-1:0] tries;
  logic [5:0]    idx;
  logic [5:0]    target;
  logic [15:0]   seed_q;
  logic          excl_en_q;
  logic [5:0]    excl_cell;

  logic [15:0] lfsr_next;
  logic [15:0] seed_mix;
  logic [15:0] seed_load;
  logic [5:0]  cand;
  logic        accept;
  logic [5:0]  placed_next;
  logic        hit;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

`ifdef MINE_SEED_FREERUN_EN
  assign seed_mix = lfsr ^ seed_q;
`else
  assign seed_mix = seed_q;
`endif
  assign seed_load = (seed_mix == 16'h0000) ? DEFAULT_SEED : seed_mix;

  assign cand        = (state == S_SCAN) ? idx : lfsr[5:0];
  assign accept      = !bomb_map[cand] && !(excl_en_q && (cand == excl_cell));
  assign placed_next = placed_count + {5'd0, accept};
  assign hit         = accept && (placed_next == target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      bomb_map     <= 64'd0;
      placed_count <= 6'd0;
      lfsr         <= DEFAULT_SEED;
      tries        <= '0;
      idx          <= 6'd0;
      target       <= 6'd0;
      seed_q       <= 16'h0000;
      excl_en_q    <= 1'b0;
      excl_cell    <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef MINE_SEED_FREERUN_EN
          lfsr <= lfsr_next;
`endif
          if (start) begin
            target    <= (bomb_count > MAX_B) ? MAX_B : bomb_count;
            seed_q    <= seed;
            excl_en_q <= excl_en;
            excl_cell <= {excl_row, excl_col};
            busy      <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          bomb_map     <= 64'd0;
          placed_count <= 6'd0;
          tries        <= '0;
          idx          <= 6'd0;
          lfsr         <= seed_load;
          state        <= (target == 6'd0) ? S_DONE : S_DRAW;
        end
        S_DRAW: begin
          lfsr  <= lfsr_next;
          tries <= tries + 1'b1;
          if (accept) begin
            bomb_map[cand] <= 1'b1;
            placed_count   <= placed_next;
          end
          if (hit)
            state <= S_DONE;
          else if (tries == TRIES_LAST)
            state <= S_SCAN;
        end
        S_SCAN: begin
          idx <= idx + 6'd1;
          if (accept) begin
            bomb_map[cand] <= 1'b1;
            placed_count   <= placed_next;
          end
          // Running off the end cannot happen for legal targets; still terminate
          if (hit || (idx == 6'd63))
            state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
